// File: rtl/mips_data_ram_responder.sv
`default_nettype none
// ============================================================================
// Module      : mips_data_ram_responder
// Description : Word-addressed data RAM answering the CPU's Harvard data
//               interface. Reads are combinational and writes happen on the
//               rising edge. After reset every word is zeroed, one word per
//               cycle. `ready` stays low until that clear sequence finishes.
//               Accesses that are misaligned, out of range, or that assert
//               read and write together are refused. The first such access
//               is latched in a sticky error flag with its address.
//
// Ports       : clk            - system clock
//               reset          - synchronous, active-high reset
//               data_address   - byte address from the CPU
//               data_read      - read request
//               data_write     - write request
//               data_writedata - write data
//               data_readdata  - combinational read data (0 when not served)
//               ready          - high once initialisation is complete
//               access_error   - sticky illegal-access flag
//               error_addr     - address of the first illegal access
//               rd_count       - legal reads in READY   (stats build only)
//               wr_count       - legal writes in READY  (stats build only)
//               err_count      - illegal accesses in READY (stats build only)
//
// Options     : define MIPS_DATA_RAM_STATS_EN to add the saturating
//               rd_count / wr_count / err_count outputs.
//
// Revision    : 1.0 - initial release
// ============================================================================
module mips_data_ram_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int          DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        ready,
    output logic        access_error,
    output logic [31:0] error_addr
`ifdef MIPS_DATA_RAM_STATS_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
    output logic [15:0] err_count
`endif
);

    localparam int              c_words = 1 << DEPTH_LOG2;
    // Span is kept 33 bits wide so very large depths cannot overflow.
    localparam logic [32:0]     c_span  = 33'd4 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] c_last = {DEPTH_LOG2{1'b1}};

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t                  r_state;
    logic [DEPTH_LOG2-1:0]   r_clear_ptr;
    logic                    r_ready;
    logic                    r_access_error;
    logic [31:0]             r_error_addr;
    logic [31:0]             r_mem [c_words];

    logic [31:0]             w_offset;
    logic                    w_in_range;
    logic                    w_aligned;
    logic                    w_legal;
    logic                    w_active;
    logic                    w_rd_legal;
    logic                    w_wr_legal;
    logic                    w_illegal;
    logic [DEPTH_LOG2-1:0]   w_index;
    logic                    w_mem_we;
    logic [DEPTH_LOG2-1:0]   w_mem_idx;
    logic [31:0]             w_mem_wdata;

    // ------------------------------------------------------------------
    // Address decode and access classification
    // ------------------------------------------------------------------
    always_comb begin
        w_offset   = data_address - BASE_ADDR;
        w_in_range = ({1'b0, w_offset} < c_span);
        w_aligned  = (data_address[1:0] == 2'b00);
        w_index    = w_offset[DEPTH_LOG2+1:2];
        w_legal    = w_in_range && w_aligned && !(data_read && data_write);
        w_active   = (r_state == S_READY);
        w_rd_legal = w_active && data_read  && w_legal;
        w_wr_legal = w_active && data_write && w_legal;
        w_illegal  = w_active && (data_read || data_write) && !w_legal;
    end

    // Single write port shared by the clear sequence and CPU writes.
    // Writes are suppressed while reset is held so the restart is clean.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_idx   = w_index;
        w_mem_wdata = data_writedata;
        if (!reset) begin
            if (r_state == S_CLEAR) begin
                w_mem_we    = 1'b1;
                w_mem_idx   = r_clear_ptr;
                w_mem_wdata = 32'd0;
            end else if (w_wr_legal) begin
                w_mem_we    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_wdata;
        end
    end

    // Combinational read returns the pre-edge contents, so a same-cycle
    // write to the same word only becomes visible on the next cycle.
    always_comb begin
        data_readdata = 32'd0;
        if (w_rd_legal) begin
            data_readdata = r_mem[w_index];
        end
    end

    // ------------------------------------------------------------------
    // Control state machine and sticky error capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_CLEAR;
            r_clear_ptr    <= '0;
            r_ready        <= 1'b0;
            r_access_error <= 1'b0;
            r_error_addr   <= 32'd0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_clear_ptr <= r_clear_ptr + 1'b1;
                    if (r_clear_ptr == c_last) begin
                        r_state <= S_READY;
                        r_ready <= 1'b1;
                    end
                end
                S_READY: begin
                    if (w_illegal && !r_access_error) begin
                        r_access_error <= 1'b1;
                        r_error_addr   <= data_address;
                    end
                end
                default: begin
                    r_state <= S_CLEAR;
                end
            endcase
        end
    end

    assign ready        = r_ready;
    assign access_error = r_access_error;
    assign error_addr   = r_error_addr;

`ifdef MIPS_DATA_RAM_STATS_EN
    // ------------------------------------------------------------------
    // Saturating access counters
    // ------------------------------------------------------------------
    logic [31:0] r_rd_count;
    logic [31:0] r_wr_count;
    logic [15:0] r_err_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_count  <= 32'd0;
            r_wr_count  <= 32'd0;
            r_err_count <= 16'd0;
        end else begin
            if (w_rd_legal && (r_rd_count != 32'hFFFF_FFFF)) begin
                r_rd_count <= r_rd_count + 32'd1;
            end
            if (w_wr_legal && (r_wr_count != 32'hFFFF_FFFF)) begin
                r_wr_count <= r_wr_count + 32'd1;
            end
            if (w_illegal && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    assign rd_count  = r_rd_count;
    assign wr_count  = r_wr_count;
    assign err_count = r_err_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_data_ram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_data_ram_responder
// Description : Directed self-checking bench for mips_data_ram_responder
//               with default parameters (BASE 0x1000, 256 words). Covers the
//               clear sequence, read/write, sticky error capture, reset
//               during clear and, in the stats build, the access counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_data_ram_responder;

    logic        clk;
    logic        reset;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic        ready;
    logic        access_error;
    logic [31:0] error_addr;
`ifdef MIPS_DATA_RAM_STATS_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;
    logic [15:0] err_count;
`endif

    int n_tests;
    int n_fail;
    int cyc;

    mips_data_ram_responder dut (
        .clk            (clk),
        .reset          (reset),
        .data_address   (data_address),
        .data_read      (data_read),
        .data_write     (data_write),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata),
        .ready          (ready),
        .access_error   (access_error),
        .error_addr     (error_addr)
`ifdef MIPS_DATA_RAM_STATS_EN
        ,
        .rd_count       (rd_count),
        .wr_count       (wr_count),
        .err_count      (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until ready rises, bounded so the bench cannot hang.
    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!ready && cycles < 1000) begin
            tick();
            cycles++;
        end
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        data_address   = addr;
        data_writedata = data;
        data_write     = 1'b1;
        tick();
        data_write     = 1'b0;
    endtask

    // Checks combinational read data, then holds the request across one
    // edge so the error logic and counters see it.
    task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        data_address = addr;
        data_read    = 1'b1;
        #1;
        check(tag, data_readdata, exp);
        tick();
        data_read    = 1'b0;
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        reset          = 1'b1;
        data_address   = 32'd0;
        data_read      = 1'b0;
        data_write     = 1'b0;
        data_writedata = 32'd0;

        // ---------------- reset state ----------------
        tick();
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_err", {31'd0, access_error}, 32'd0);
        check("rst_eaddr", error_addr, 32'd0);
        reset = 1'b0;

        // Illegal read held during the clear must be ignored.
        data_address = 32'h0000_1400;
        data_read    = 1'b1;
        #1;
        check("clear_rdata", data_readdata, 32'd0);
        wait_ready(cyc);
        check("clear_cycles", cyc, 32'd256);
        check("clear_noerr", {31'd0, access_error}, 32'd0);
        data_read = 1'b0;

        // ---------------- basic read / write ----------------
        do_read("rd_base", 32'h0000_1000, 32'd0);
        do_read("rd_top", 32'h0000_13FC, 32'd0);
        data_address   = 32'h0000_1004;
        data_writedata = 32'hDEAD_BEEF;
        data_write     = 1'b1;
        #1;
        check("wr_cycle_rdata", data_readdata, 32'd0);
        tick();
        data_write = 1'b0;
        do_read("rd_after_wr", 32'h0000_1004, 32'hDEAD_BEEF);
        do_write(32'h0000_13FC, 32'hCAFE_0001);
        do_read("rd_top_wr", 32'h0000_13FC, 32'hCAFE_0001);
        check("legal_noerr", {31'd0, access_error}, 32'd0);

        // ---------------- misaligned write, sticky address ----------------
        do_write(32'h0000_1006, 32'h1234_5678);
        check("mis_err", {31'd0, access_error}, 32'd1);
        check("mis_eaddr", error_addr, 32'h0000_1006);
        do_read("mis_nochange", 32'h0000_1004, 32'hDEAD_BEEF);
        do_write(32'h0000_0FFC, 32'h1111_1111);
        check("sticky_eaddr", error_addr, 32'h0000_1006);
        do_read("base_nochange", 32'h0000_1000, 32'd0);

        // ---------------- one past the top ----------------
        reset_pulse();
        check("rst2_err", {31'd0, access_error}, 32'd0);
        wait_ready(cyc);
        check("clear2_cycles", cyc, 32'd256);
        do_read("cleared_1004", 32'h0000_1004, 32'd0);
        do_read("oor_rdata", 32'h0000_1400, 32'd0);
        check("oor_err", {31'd0, access_error}, 32'd1);
        check("oor_eaddr", error_addr, 32'h0000_1400);

        // ---------------- read and write together ----------------
        reset_pulse();
        wait_ready(cyc);
        data_address   = 32'h0000_1008;
        data_writedata = 32'hA5A5_A5A5;
        data_read      = 1'b1;
        data_write     = 1'b1;
        #1;
        check("rw_rdata", data_readdata, 32'd0);
        tick();
        data_read  = 1'b0;
        data_write = 1'b0;
        check("rw_err", {31'd0, access_error}, 32'd1);
        check("rw_eaddr", error_addr, 32'h0000_1008);
        do_read("rw_nowrite", 32'h0000_1008, 32'd0);

        // ---------------- reset during clear ----------------
        reset_pulse();
        for (int i = 0; i < 10; i++) tick();
        check("midclear_ready", {31'd0, ready}, 32'd0);
        reset_pulse();
        check("midclear_err", {31'd0, access_error}, 32'd0);
        check("midclear_eaddr", error_addr, 32'd0);
        wait_ready(cyc);
        check("midclear_cycles", cyc, 32'd256);

`ifdef MIPS_DATA_RAM_STATS_EN
        // ---------------- statistics counters ----------------
        reset_pulse();
        check("st_rst_wr", wr_count, 32'd0);
        wait_ready(cyc);
        do_write(32'h0000_1000, 32'h0000_0001);
        do_write(32'h0000_1010, 32'h0000_0002);
        do_write(32'h0000_1020, 32'h0000_0003);
        do_read("st_rd0", 32'h0000_1010, 32'h0000_0002);
        do_read("st_rd1", 32'h0000_1020, 32'h0000_0003);
        do_read("st_mis", 32'h0000_1002, 32'd0);
        check("st_wr", wr_count, 32'd3);
        check("st_rd", rd_count, 32'd2);
        check("st_errc", {16'd0, err_count}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
